// File: rtl/multi_debounce_if.sv
// Pin-side bundle for the multi-channel debouncer: raw inputs in, conditioned level/pulses out.
// The slave modport is the debouncer's view; the master modport is the driver/consumer side.
interface multi_debounce_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] din;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] hold;
  logic            any_evt;

  modport master (output din, input level, rise, fall, hold, any_evt);
  modport slave  (input din, output level, rise, fall, hold, any_evt);
endinterface

// File: rtl/multi_debounce.sv
// Per-channel 2-flop synchroniser + stable-level debounce filter with rise/fall/hold pulses.
// Level follows din after DEBOUNCE_COUNT+2 edges; no backpressure, every channel reports independently.
module multi_debounce #(
  parameter int   N_CH           = 4,
  parameter int   DEBOUNCE_COUNT = 16,
  parameter int   HOLD_COUNT     = 1000,
  parameter int   REPEAT_COUNT   = 250,
  parameter logic INIT_LEVEL     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  multi_debounce_if.slave bus
);
  localparam int DW   = $clog2(DEBOUNCE_COUNT + 1);
  localparam int HMAX = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
  localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNT - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_COUNT - 1);

  typedef enum logic {PH_FIRST, PH_REPEAT} phase_t;

  logic [N_CH-1:0] s1, s2;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [N_CH-1:0] hold_q, hold_d;
  logic [DW-1:0]   cnt_q   [N_CH];
  logic [DW-1:0]   cnt_d   [N_CH];
  logic [HW-1:0]   hcnt_q  [N_CH];
  logic [HW-1:0]   hcnt_d  [N_CH];
  phase_t          phase_q [N_CH];
  phase_t          phase_d [N_CH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= {N_CH{INIT_LEVEL}};
      s2      <= {N_CH{INIT_LEVEL}};
      level_q <= {N_CH{INIT_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      hold_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= '0;
        hcnt_q[i]  <= '0;
        phase_q[i] <= PH_FIRST;
      end
    end else begin
      s1      <= bus.din;
      s2      <= s1;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    hold_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      hcnt_d[i]  = hcnt_q[i];
      phase_d[i] = phase_q[i];

      // Any sample matching the current level restarts the stability window.
      if (s2[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i] = s2[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s2[i];
        fall_d[i]  = ~s2[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      // Rise edges see level_q==0 here, so hold restarts from zero and can never coincide with rise;
      // an accepted fall pre-empts a hold pulse due on the same edge.
      if (HOLD_COUNT == 0 || !level_q[i] || fall_d[i]) begin
        hcnt_d[i]  = '0;
        phase_d[i] = PH_FIRST;
      end else if (phase_q[i] == PH_FIRST) begin
        if (hcnt_q[i] == HOLD_LAST) begin
          hold_d[i]  = 1'b1;
          hcnt_d[i]  = '0;
          phase_d[i] = PH_REPEAT;
        end else begin
          hcnt_d[i] = hcnt_q[i] + 1'b1;
        end
      end else if (REPEAT_COUNT != 0) begin
        if (hcnt_q[i] == REP_LAST) begin
          hold_d[i] = 1'b1;
          hcnt_d[i] = '0;
        end else begin
          hcnt_d[i] = hcnt_q[i] + 1'b1;
        end
      end else if (hcnt_q[i] != '1) begin
        hcnt_d[i] = hcnt_q[i] + 1'b1;
      end
    end
  end

  assign bus.level   = level_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.hold    = hold_q;
  assign bus.any_evt = |(rise_q | fall_q | hold_q);
endmodule

// File: tb/tb_multi_debounce.sv
// Randomised + directed bench for multi_debounce: window-based reference model checked every cycle,
// plus literal expectations for latency, glitch rejection, hold/repeat, fall-vs-hold and reset cases.
module tb_multi_debounce;
  localparam int   N_CH = 4;
  localparam int   DC   = 4;
  localparam int   HC   = 10;
  localparam int   RC   = 3;
  localparam logic INIT = 1'b0;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rel      = 0;

  multi_debounce_if #(.N_CH(N_CH)) bus ();
  multi_debounce_if #(.N_CH(N_CH)) bus1 ();

  multi_debounce #(.N_CH(N_CH), .DEBOUNCE_COUNT(DC), .HOLD_COUNT(HC), .REPEAT_COUNT(RC),
                   .INIT_LEVEL(INIT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  multi_debounce #(.N_CH(N_CH), .DEBOUNCE_COUNT(DC), .HOLD_COUNT(HC), .REPEAT_COUNT(RC),
                   .INIT_LEVEL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rel++;
  endtask

  // Reference model: level flips once the last DC synchronised samples all disagree with it;
  // hold fires at HC, HC+RC, HC+2RC... edges after level became 1 (rise or reset release).
  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] m_level, m_rise, m_fall, m_hold;
  int              anchor[N_CH];
  int              t = 0;
  bit              m_valid = 0;

  initial begin
    forever begin
      @(posedge clk);
      t++;
      if (!reset) begin
        hist.delete();
        for (int k = 0; k < DC + 2; k++) hist.push_back({N_CH{INIT}});
        m_level = {N_CH{INIT}};
        m_rise  = '0;
        m_fall  = '0;
        m_hold  = '0;
        for (int c = 0; c < N_CH; c++) anchor[c] = t;
      end else begin
        hist.push_front(bus.din);
        void'(hist.pop_back());
        for (int c = 0; c < N_CH; c++) begin
          logic old;
          bit   acc;
          int   kk;
          old = m_level[c];
          acc = 1'b1;
          for (int k = 0; k < DC; k++) if (hist[2+k][c] == old) acc = 1'b0;
          m_rise[c] = acc && !old;
          m_fall[c] = acc && old;
          m_hold[c] = 1'b0;
          if (HC > 0 && old && !acc) begin
            kk = t - anchor[c];
            if (kk == HC || (RC > 0 && kk > HC && (kk - HC) % RC == 0)) m_hold[c] = 1'b1;
          end
          if (acc) m_level[c] = ~old;
          if (m_rise[c]) anchor[c] = t;
        end
      end
      m_valid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model level", bus.level, m_level);
        chk("model rise", bus.rise, m_rise);
        chk("model fall", bus.fall, m_fall);
        chk("model hold", bus.hold, m_hold);
        chk("model any_evt", bus.any_evt, |(m_rise | m_fall | m_hold));
      end
    end
  end

  // INIT_LEVEL=1 build: high out of reset, never a rise, holds counted from reset release.
  initial begin
    bus1.din = {N_CH{1'b1}};
    repeat (3) begin
      @(negedge clk);
      chk("init1 level in reset", bus1.level, 4'hF);
      chk("init1 rise in reset", bus1.rise, 4'h0);
    end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("init1 level", bus1.level, 4'hF);
      chk("init1 rise", bus1.rise, 4'h0);
      chk("init1 hold", bus1.hold, (k == 10 || k == 13) ? 4'hF : 4'h0);
    end
  end

  initial begin
    logic seen;
    int   rate;
    reset   = 1'b0;
    bus.din = 4'hF;

    // Reset holds everything low regardless of din.
    repeat (3) begin
      step();
      chk("t1 level", bus.level, 4'h0);
      chk("t1 pulses", {bus.rise, bus.fall, bus.hold}, 12'h0);
      chk("t1 any_evt", bus.any_evt, 1'b0);
    end
    reset   = 1'b1;
    bus.din = 4'h1;
    rel     = 0;

    // Rise latency.
    repeat (5) step();
    chk("t2 level before", bus.level[0], 1'b0);
    step();
    chk("t2 level", bus.level[0], 1'b1);
    chk("t2 rise", bus.rise[0], 1'b1);
    step();
    chk("t2 rise one cycle", bus.rise[0], 1'b0);

    // Glitches of 3 cycles never get through.
    seen = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.din[1] = 1'b1;
      repeat (3) begin step(); seen |= bus.rise[1] | bus.fall[1]; end
      bus.din[1] = 1'b0;
      repeat (3) begin step(); seen |= bus.rise[1] | bus.fall[1]; end
    end
    repeat (6) begin step(); seen |= bus.rise[1] | bus.fall[1]; end
    chk("t3 no edge", seen, 1'b0);
    chk("t3 level", bus.level[1], 1'b0);

    // Long press, repeat, and fall landing exactly on a hold slot.
    bus.din[2] = 1'b1;
    rel = 0;
    while (rel < 6) step();
    chk("t4 rise", bus.rise[2], 1'b1);
    while (rel < 15) step();
    chk("t4 no early hold", bus.hold[2], 1'b0);
    step();
    chk("t4 first hold", bus.hold[2], 1'b1);
    while (rel < 19) step();
    chk("t4 repeat1", bus.hold[2], 1'b1);
    while (rel < 22) step();
    chk("t4 repeat2", bus.hold[2], 1'b1);
    while (rel < 37) step();
    bus.din[2] = 1'b0;
    while (rel < 43) step();
    chk("t4 fall", bus.fall[2], 1'b1);
    chk("t4 fall beats hold", bus.hold[2], 1'b0);
    chk("t4 level", bus.level[2], 1'b0);
    seen = 1'b0;
    repeat (10) begin step(); seen |= bus.hold[2]; end
    chk("t4 no hold after fall", seen, 1'b0);

    // Simultaneous rises on two channels.
    bus.din = 4'h0;
    repeat (20) step();
    bus.din = 4'b1010;
    rel = 0;
    while (rel < 6) step();
    chk("t5 rise", bus.rise, 4'b1010);
    chk("t5 any_evt", bus.any_evt, 1'b1);
    step();
    chk("t5 any_evt drop", bus.any_evt, 1'b0);

    // Reset mid-debounce (cnt=2) and mid-hold.
    bus.din = 4'h0;
    repeat (20) step();
    bus.din = 4'h1;
    rel = 0;
    while (rel < 4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    seen = 1'b0;
    while (rel < 10) begin step(); seen |= bus.level[0] | bus.rise[0]; end
    chk("t6 debounce discarded", seen, 1'b0);
    step();
    chk("t6 late rise", bus.rise[0], 1'b1);
    while (rel < 16) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t6 reset level", bus.level[0], 1'b0);
    chk("t6 reset any_evt", bus.any_evt, 1'b0);
    seen = 1'b0;
    while (rel < 32) begin step(); seen |= bus.hold[0]; end
    chk("t6 hold discarded", seen, 1'b0);
    step();
    chk("t6 hold restarted", bus.hold[0], 1'b1);

    // Random phase with varying toggle rates and occasional resets.
    rate = 6;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) rate = (n % 600 == 0) ? 3 : ((n % 600 == 200) ? 8 : 40);
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, rate - 1) == 0) bus.din[c] = ~bus.din[c];
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
